// File: rtl/alu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_step_sequencer
// Brief    : T0-T5 control-step generator for three-register ALU instructions.
// Revision : 1.0
// ============================================================================
module alu_step_sequencer #(
  parameter int                  OP_WIDTH    = 5,
  parameter int                  REG_FIELD   = 4,
  parameter logic [OP_WIDTH-1:0] OP_MIN      = 5'b00011,
  parameter logic [OP_WIDTH-1:0] OP_MAX      = 5'b01010,
  parameter int                  MEM_TIMEOUT = 15,
  parameter int                  COUNT_WIDTH = 16
) (
  input  logic                        Clock,
  input  logic                        Clear,
  input  logic                        Start,
  input  logic                        Run,
  input  logic [31:0]                 IR,
  input  logic                        Mem_Ready,
  output logic                        PC_Out,
  output logic                        MAR_In,
  output logic                        IncPC,
  output logic                        Z_In,
  output logic                        ZLO_Out,
  output logic                        PC_In,
  output logic                        Read,
  output logic                        MDR_In,
  output logic                        MDR_Out,
  output logic                        IR_In,
  output logic                        Y_In,
  output logic [(2**REG_FIELD)-1:0]   R_Out,
  output logic [(2**REG_FIELD)-1:0]   R_In,
  output logic [OP_WIDTH-1:0]         ALU_Ctrl,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Illegal,
  output logic                        Bus_Error,
  output logic [COUNT_WIDTH-1:0]      Instr_Count
);

  localparam int c_NUM_REGS = 2**REG_FIELD;
  localparam int c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam int c_LOW_BITS = 32 - OP_WIDTH - 3*REG_FIELD;
  localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [c_NUM_REGS-1:0] c_ONE       = {{(c_NUM_REGS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_WAIT_W-1:0]    r_wait;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [OP_WIDTH-1:0]    w_op;
  logic [REG_FIELD-1:0]   w_ra;
  logic [REG_FIELD-1:0]   w_rb;
  logic [REG_FIELD-1:0]   w_rc;
  logic                   w_legal;
  logic                   w_wait_last;

  assign w_op  = IR[31 -: OP_WIDTH];
  assign w_ra  = IR[31-OP_WIDTH -: REG_FIELD];
  assign w_rb  = IR[31-OP_WIDTH-REG_FIELD -: REG_FIELD];
  assign w_rc  = IR[31-OP_WIDTH-2*REG_FIELD -: REG_FIELD];
  assign w_legal     = (w_op >= OP_MIN) && (w_op <= OP_MAX);
  // r_wait holds (T1 cycle number - 1), so this marks the MEM_TIMEOUT-th T1 cycle
  assign w_wait_last = (r_wait == c_WAIT_LAST);

  generate
    if (c_LOW_BITS > 0) begin : g_unused_ir
      logic w_unused_ir_bits;
      assign w_unused_ir_bits = ^IR[c_LOW_BITS-1:0];
    end
  endgenerate

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      if (r_state != S_T1) begin
        r_wait <= '0;
      end else if (!Mem_Ready && !w_wait_last) begin
        r_wait <= r_wait + 1'b1;
      end
      if (Done) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign Instr_Count = r_count;
  assign Busy        = (r_state != S_IDLE);

  always_comb begin
    w_next    = r_state;
    PC_Out    = 1'b0;
    MAR_In    = 1'b0;
    IncPC     = 1'b0;
    Z_In      = 1'b0;
    ZLO_Out   = 1'b0;
    PC_In     = 1'b0;
    Read      = 1'b0;
    MDR_In    = 1'b0;
    MDR_Out   = 1'b0;
    IR_In     = 1'b0;
    Y_In      = 1'b0;
    R_Out     = '0;
    R_In      = '0;
    ALU_Ctrl  = '0;
    Done      = 1'b0;
    Illegal   = 1'b0;
    Bus_Error = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_next = S_T0;
      end
      S_T0: begin
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
        Z_In   = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
        Read    = 1'b1;
        MDR_In  = Mem_Ready;
        // Ready on the last allowed cycle still wins over the timeout
        if (Mem_Ready) begin
          w_next = S_T2;
        end else if (w_wait_last) begin
          Bus_Error = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_T2: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        if (w_legal) begin
          R_Out  = c_ONE << w_rb;
          Y_In   = 1'b1;
          w_next = S_T4;
        end else begin
          Illegal = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_T4: begin
        R_Out    = c_ONE << w_rc;
        ALU_Ctrl = w_op;
        Z_In     = 1'b1;
        w_next   = S_T5;
      end
      S_T5: begin
        ZLO_Out = 1'b1;
        R_In    = c_ONE << w_ra;
        Done    = 1'b1;
        w_next  = Run ? S_T0 : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_step_sequencer.sv
`default_nettype none
// Directed bench for alu_step_sequencer: vector table plus stall/timeout/reset/run sequences.
module tb_alu_step_sequencer;

  localparam int CW = 2;

  logic          Clock, Clear, Start, Run, Mem_Ready;
  logic [31:0]   IR;
  logic          PC_Out, MAR_In, IncPC, Z_In, ZLO_Out, PC_In, Read, MDR_In;
  logic          MDR_Out, IR_In, Y_In, Busy, Done, Illegal, Bus_Error;
  logic [15:0]   R_Out, R_In;
  logic [4:0]    ALU_Ctrl;
  logic [CW-1:0] Instr_Count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  alu_step_sequencer #(.COUNT_WIDTH(CW)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Run(Run), .IR(IR),
    .Mem_Ready(Mem_Ready), .PC_Out(PC_Out), .MAR_In(MAR_In), .IncPC(IncPC),
    .Z_In(Z_In), .ZLO_Out(ZLO_Out), .PC_In(PC_In), .Read(Read),
    .MDR_In(MDR_In), .MDR_Out(MDR_Out), .IR_In(IR_In), .Y_In(Y_In),
    .R_Out(R_Out), .R_In(R_In), .ALU_Ctrl(ALU_Ctrl), .Busy(Busy),
    .Done(Done), .Illegal(Illegal), .Bus_Error(Bus_Error),
    .Instr_Count(Instr_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] ir;
    logic [15:0] r3;
    logic        y;
    logic [15:0] r4;
    logic [4:0]  alu;
    logic [15:0] rin;
    logic        ill;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] cnt_mod(input int c);
    return 32'(c % (1 << CW));
  endfunction

  initial begin
    int cyc;
    int wrap_exp[5];
    wrap_exp = '{1, 2, 3, 0, 1};

    vecs[0] = '{32'h5292_0000, 16'h0004, 1'b1, 16'h0010, 5'h0A, 16'h0020, 1'b0};
    vecs[1] = '{32'h1BBB_8000, 16'h0080, 1'b1, 16'h0080, 5'h03, 16'h0080, 1'b0};
    vecs[2] = '{32'h2878_0000, 16'h8000, 1'b1, 16'h0001, 5'h05, 16'h0001, 1'b0};
    vecs[3] = '{32'h1000_0000, 16'h0000, 1'b0, 16'h0000, 5'h00, 16'h0000, 1'b1};
    vecs[4] = '{32'h5800_0000, 16'h0000, 1'b0, 16'h0000, 5'h00, 16'h0000, 1'b1};
    vecs[5] = '{32'hF800_0000, 16'h0000, 1'b0, 16'h0000, 5'h00, 16'h0000, 1'b1};

    Clear = 1'b1; Start = 1'b0; Run = 1'b0; Mem_Ready = 1'b0; IR = '0;
    tick(); tick();
    check("reset_busy", Busy, 0);
    check("reset_pc_out", PC_Out, 0);
    check("reset_r_out", R_Out, 0);
    check("reset_count", Instr_Count, 0);
    Clear = 1'b0;
    tick();
    check("idle_busy", Busy, 0);

    // Table: one full instruction per vector; Start held high to show it is ignored mid-run
    for (int v = 0; v < 6; v++) begin
      IR = vecs[v].ir; Mem_Ready = 1'b1; Start = 1'b1;
      tick();
      check("t0_pc_out", PC_Out, 1);
      check("t0_z_in", Z_In, 1);
      tick();
      check("t1_read", Read, 1);
      check("t1_mdr_in", MDR_In, 1);
      tick();
      check("t2_ir_in", IR_In, 1);
      tick();
      check("t3_r_out", R_Out, vecs[v].r3);
      check("t3_y_in", Y_In, vecs[v].y);
      check("t3_illegal", Illegal, vecs[v].ill);
      if (vecs[v].ill) begin
        Start = 1'b0;
        tick();
        check("ill_busy", Busy, 0);
        check("ill_count", Instr_Count, cnt_mod(exp_count));
      end else begin
        tick();
        check("t4_r_out", R_Out, vecs[v].r4);
        check("t4_alu", ALU_Ctrl, vecs[v].alu);
        Start = 1'b0;
        tick();
        check("t5_r_in", R_In, vecs[v].rin);
        check("t5_done", Done, 1);
        check("t5_alu_zero", ALU_Ctrl, 0);
        exp_count++;
        tick();
        check("post_busy", Busy, 0);
        check("post_count", Instr_Count, cnt_mod(exp_count));
      end
    end

    // Memory stall: three not-ready T1 cycles then ready
    IR = vecs[0].ir; Mem_Ready = 1'b0; Start = 1'b1;
    tick(); Start = 1'b0; cyc = 1;
    for (int i = 1; i <= 3; i++) begin
      tick(); cyc++;
      check("stall_read", Read, 1);
      check("stall_mdr_in", MDR_In, 0);
    end
    tick(); cyc++;
    Mem_Ready = 1'b1;
    #1;
    check("stall_mdr_in_4", MDR_In, 1);
    while (!Done && cyc < 20) begin
      tick(); cyc++;
    end
    check("stall_done", Done, 1);
    check("stall_cycles", cyc, 9);
    exp_count++;
    tick();
    check("stall_count", Instr_Count, cnt_mod(exp_count));

    // Fetch timeout: Bus_Error only in the 15th T1 cycle
    Mem_Ready = 1'b0; Start = 1'b1;
    tick(); Start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("to_read", Read, 1);
      check("to_bus_error", Bus_Error, (i == 15) ? 1 : 0);
      check("to_done", Done, 0);
    end
    tick();
    check("to_busy", Busy, 0);
    check("to_bus_error_clr", Bus_Error, 0);
    check("to_count", Instr_Count, cnt_mod(exp_count));

    // Ready arriving on the 15th T1 cycle rescues the fetch
    Mem_Ready = 1'b0; Start = 1'b1;
    tick(); Start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15) Mem_Ready = 1'b1;
      #1;
      check("late_bus_error", Bus_Error, 0);
      check("late_mdr_in", MDR_In, (i == 15) ? 1 : 0);
    end
    tick(); tick(); tick(); tick();
    check("late_done", Done, 1);
    exp_count++;
    tick();
    check("late_count", Instr_Count, cnt_mod(exp_count));

    // Asynchronous clear during T4
    IR = vecs[0].ir; Mem_Ready = 1'b1; Start = 1'b1;
    tick(); Start = 1'b0;
    tick(); tick(); tick(); tick();
    check("mid_t4_alu", ALU_Ctrl, 5'h0A);
    #1 Clear = 1'b1;
    #1;
    check("mid_clr_r_out", R_Out, 0);
    check("mid_clr_alu", ALU_Ctrl, 0);
    check("mid_clr_z_in", Z_In, 0);
    check("mid_clr_busy", Busy, 0);
    check("mid_clr_count", Instr_Count, 0);
    exp_count = 0;
    tick();
    Clear = 1'b0; Start = 1'b1;
    tick(); Start = 1'b0;
    check("after_clr_t0", PC_Out, 1);
    tick(); tick(); tick(); tick(); tick();
    check("after_clr_done", Done, 1);
    exp_count++;
    tick();
    check("after_clr_count", Instr_Count, cnt_mod(exp_count));

    // Continuous run: five instructions, 2-bit counter wraps
    Clear = 1'b1;
    tick();
    Clear = 1'b0; Run = 1'b1; Start = 1'b1;
    tick(); Start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("run_t0", PC_Out, 1);
      tick(); tick(); tick(); tick();
      check("run_pre_done", Done, 0);
      tick();
      check("run_done", Done, 1);
      if (n == 4) Run = 1'b0;
      tick();
      check("run_count", Instr_Count, 32'(wrap_exp[n]));
    end
    check("run_end_busy", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
